hazard_ctrl: RTL and testbench

- Hazard/control consumer for the 3-stage pipeline (IF | DE+EX | MEM+WB).
- Sits on the receiving end of the rd/instruction data flowing forward through the inter-stage IR buffers. It compares the EX-stage instruction's sources with the MEM/WB destination.
- Drives forwarding selects, load-use stall/bubble, and taken-branch redirect/flush back toward IF and the IR buffers.
- Small FSM stretches stalls and flushes across multiple cycles for multi-cycle memories.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hz_src_decode.sv | 51 +++++
 rtl/hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the 3-stage pipeline hazard controller:
// RV32 opcode values, hazard FSM state encoding and the canonical NOP.
package hazard_pkg;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   // addi x0, x0, 0
   localparam logic [31:0] NOP = 32'h00000013;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      FLUSH    = 2'd2
   } hz_state_t;

endpackage

// File: rtl/hz_src_decode.sv
// Source-register decode for the EX-stage instruction: extracts rs1/rs2
// and flags which of them the opcode actually reads, so that stale field
// bits in U/J-type encodings never raise a false hazard.
module hz_src_decode
   import hazard_pkg::*;
(
   input  logic [31:0] ex_instr,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic        rs1_used,
   output logic        rs2_used
);

   logic [6:0] opcode;
   logic       unused_bits;

   assign opcode = ex_instr[6:0];
   assign rs1    = ex_instr[19:15];
   assign rs2    = ex_instr[24:20];

   // funct/rd/immediate bits play no part in source detection
   assign unused_bits = ^{ex_instr[31:25], ex_instr[14:7]};

   // Which source fields are architecturally read by this opcode
   always_comb begin
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      case (opcode)
         OP: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         OP_IMM: rs1_used = 1'b1;
         LOAD:   rs1_used = 1'b1;
         STORE: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         BRANCH: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         JALR:   rs1_used = 1'b1;
         default: begin
            rs1_used = 1'b0;
            rs2_used = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard / control unit for the IF | DE+EX | MEM+WB pipeline.
// Compares EX sources against the MEM/WB destination to drive forwarding,
// load-use stall/bubble and taken-branch redirect/flush. A small FSM
// stretches stalls and flushes over LOAD_STALL_CYCLES / FLUSH_CYCLES.
// Optional build macro HAZARD_PERF_EN adds stall_cnt / flush_cnt counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 2
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ex_instr,
   input  logic [4:0]  mw_rd,
   input  logic        mw_reg_wr,
   input  logic        mw_is_load,
   input  logic        br_taken,
   output logic        fwd_a,
   output logic        fwd_b,
   output logic        stall_if,
   output logic        bubble_mw,
   output logic        flush_ex,
   output logic        pc_redirect,
   output logic        busy
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   localparam int CNT_MAX = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic [4:0]       rs1;
   logic [4:0]       rs2;
   logic             rs1_used;
   logic             rs2_used;
   logic             match_a;
   logic             match_b;
   logic             load_use;

   hz_state_t        state_reg;
   hz_state_t        state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   logic             fwd_a_raw;
   logic             fwd_b_raw;
   logic             stall_raw;
   logic             bubble_raw;
   logic             flush_raw;
   logic             redirect_raw;

   hz_src_decode u_src_decode (
      .ex_instr (ex_instr),
      .rs1      (rs1),
      .rs2      (rs2),
      .rs1_used (rs1_used),
      .rs2_used (rs2_used)
   );

   // x0 is hard-wired zero, so a write to it never creates a dependency
   assign match_a  = rs1_used & (rs1 == mw_rd) & (mw_rd != 5'd0) & mw_reg_wr;
   assign match_b  = rs2_used & (rs2 == mw_rd) & (mw_rd != 5'd0) & mw_reg_wr;
   assign load_use = (match_a | match_b) & mw_is_load;

   // Next-state and raw output decode; load-use has priority over a branch
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      fwd_a_raw    = 1'b0;
      fwd_b_raw    = 1'b0;
      stall_raw    = 1'b0;
      bubble_raw   = 1'b0;
      flush_raw    = 1'b0;
      redirect_raw = 1'b0;
      case (state_reg)
         RUN: begin
            stall_raw  = load_use;
            bubble_raw = load_use;
            fwd_a_raw  = match_a & ~mw_is_load;
            fwd_b_raw  = match_b & ~mw_is_load;
            if (load_use) begin
               if (LOAD_STALL_CYCLES > 1) begin
                  state_next = LD_STALL;
                  cnt_next   = CNT_W'(LOAD_STALL_CYCLES - 1);
               end
            end else if (br_taken) begin
               redirect_raw = 1'b1;
               flush_raw    = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_next = FLUSH;
                  cnt_next   = CNT_W'(FLUSH_CYCLES - 1);
               end
            end
         end
         LD_STALL: begin
            stall_raw  = 1'b1;
            bubble_raw = 1'b1;
            if (cnt_reg == CNT_W'(1)) begin
               state_next = RUN;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         FLUSH: begin
            flush_raw = 1'b1;
            if (cnt_reg == CNT_W'(1)) begin
               state_next = RUN;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         default: begin
            state_next = RUN;
            cnt_next   = '0;
         end
      endcase
   end

   // FSM state and remaining-cycle counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= RUN;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Outputs are held low for as long as reset is asserted
   assign fwd_a       = rst & fwd_a_raw;
   assign fwd_b       = rst & fwd_b_raw;
   assign stall_if    = rst & stall_raw;
   assign bubble_mw   = rst & bubble_raw;
   assign flush_ex    = rst & flush_raw;
   assign pc_redirect = rst & redirect_raw;
   assign busy        = rst & (state_reg != RUN);

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_reg;
   logic [31:0] flush_cnt_reg;

   // Free-running event counters, wrapping naturally at 2^32
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         if (stall_if) stall_cnt_reg <= stall_cnt_reg + 32'd1;
         if (flush_ex) flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
   end

   assign stall_cnt = rst ? stall_cnt_reg : 32'd0;
   assign flush_cnt = rst ? flush_cnt_reg : 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances with different stall and
// flush lengths share one stimulus stream; a cycle-level reference model
// pushes expected outputs, and a negedge monitor pops and compares them.
module tb_hazard_ctrl;

   localparam int NDUT = 2;
   localparam int LS_TAB [NDUT] = '{1, 3};
   localparam int FL_TAB [NDUT] = '{2, 3};

   typedef struct packed {
      logic fwd_a;
      logic fwd_b;
      logic stall_if;
      logic bubble_mw;
      logic flush_ex;
      logic pc_redirect;
      logic busy;
   } exp_t;

   typedef struct {
      int          cyc;
      exp_t        e;
      logic [31:0] sc;
      logic [31:0] fc;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ex_instr;
   logic [4:0]  mw_rd;
   logic        mw_reg_wr;
   logic        mw_is_load;
   logic        br_taken;

   logic        fwd_a       [NDUT];
   logic        fwd_b       [NDUT];
   logic        stall_if    [NDUT];
   logic        bubble_mw   [NDUT];
   logic        flush_ex    [NDUT];
   logic        pc_redirect [NDUT];
   logic        busy        [NDUT];
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt   [NDUT];
   logic [31:0] flush_cnt   [NDUT];
`endif

   sb_t         sb_q [NDUT][$];
   int          stall_left [NDUT];
   int          flush_left [NDUT];
   logic [31:0] m_sc [NDUT];
   logic [31:0] m_fc [NDUT];
   int          cyc_num = 0;
   int          n_vec = 0;
   int          n_miss = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      hazard_ctrl #(
         .LOAD_STALL_CYCLES (LS_TAB[gi]),
         .FLUSH_CYCLES      (FL_TAB[gi])
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .ex_instr    (ex_instr),
         .mw_rd       (mw_rd),
         .mw_reg_wr   (mw_reg_wr),
         .mw_is_load  (mw_is_load),
         .br_taken    (br_taken),
         .fwd_a       (fwd_a[gi]),
         .fwd_b       (fwd_b[gi]),
         .stall_if    (stall_if[gi]),
         .bubble_mw   (bubble_mw[gi]),
         .flush_ex    (flush_ex[gi]),
         .pc_redirect (pc_redirect[gi]),
         .busy        (busy[gi])
`ifdef HAZARD_PERF_EN
         ,
         .stall_cnt   (stall_cnt[gi]),
         .flush_cnt   (flush_cnt[gi])
`endif
      );
   end

   // Which RV32 opcodes read rs1 / rs2
   function automatic bit reads_rs1(input logic [6:0] opc);
      return (opc == 7'h33) || (opc == 7'h13) || (opc == 7'h03) ||
             (opc == 7'h23) || (opc == 7'h63) || (opc == 7'h67);
   endfunction

   function automatic bit reads_rs2(input logic [6:0] opc);
      return (opc == 7'h33) || (opc == 7'h23) || (opc == 7'h63);
   endfunction

   // Drive one cycle of inputs, predict each instance's response, advance one clock
   task automatic step(input logic r, input logic [31:0] ins, input logic [4:0] rd,
                       input logic wr, input logic ld, input logic br);
      sb_t  s;
      exp_t e;
      bit   ma, mb, lu;
      logic [4:0] s1, s2;
      rst = r; ex_instr = ins; mw_rd = rd; mw_reg_wr = wr; mw_is_load = ld; br_taken = br;
      s1 = ins[19:15];
      s2 = ins[24:20];
      ma = reads_rs1(ins[6:0]) && (s1 == rd) && (rd != 5'd0) && wr;
      mb = reads_rs2(ins[6:0]) && (s2 == rd) && (rd != 5'd0) && wr;
      lu = (ma || mb) && ld;
      for (int d = 0; d < NDUT; d++) begin
         e = '0;
         s.cyc = cyc_num;
         s.sc  = 32'd0;
         s.fc  = 32'd0;
         if (r) begin
            s.sc   = m_sc[d];
            s.fc   = m_fc[d];
            e.busy = (stall_left[d] > 0) || (flush_left[d] > 0);
            if (stall_left[d] > 0) begin
               e.stall_if = 1'b1; e.bubble_mw = 1'b1;
               stall_left[d]--;
            end else if (flush_left[d] > 0) begin
               e.flush_ex = 1'b1;
               flush_left[d]--;
            end else if (lu) begin
               e.stall_if = 1'b1; e.bubble_mw = 1'b1;
               stall_left[d] = LS_TAB[d] - 1;
            end else begin
               e.fwd_a = ma;
               e.fwd_b = mb;
               if (br) begin
                  e.pc_redirect = 1'b1; e.flush_ex = 1'b1;
                  flush_left[d] = FL_TAB[d] - 1;
               end
            end
            m_sc[d] = m_sc[d] + 32'(e.stall_if);
            m_fc[d] = m_fc[d] + 32'(e.flush_ex);
         end else begin
            stall_left[d] = 0;
            flush_left[d] = 0;
            m_sc[d] = 32'd0;
            m_fc[d] = 32'd0;
         end
         s.e = e;
         sb_q[d].push_back(s);
      end
      @(posedge clk);
      #1;
      cyc_num++;
   endtask

   task automatic chk(input string nm, input int d, input int cyc,
                      input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, d, cyc, act, exp);
      end
   endtask

   // Monitor: every cycle each instance presents a full output set to compare
   always @(negedge clk) begin : mon
      sb_t s;
      for (int d = 0; d < NDUT; d++) begin
         if (sb_q[d].size() > 0) begin
            s = sb_q[d].pop_front();
            chk("fwd_a",       d, s.cyc, 32'(fwd_a[d]),       32'(s.e.fwd_a));
            chk("fwd_b",       d, s.cyc, 32'(fwd_b[d]),       32'(s.e.fwd_b));
            chk("stall_if",    d, s.cyc, 32'(stall_if[d]),    32'(s.e.stall_if));
            chk("bubble_mw",   d, s.cyc, 32'(bubble_mw[d]),   32'(s.e.bubble_mw));
            chk("flush_ex",    d, s.cyc, 32'(flush_ex[d]),    32'(s.e.flush_ex));
            chk("pc_redirect", d, s.cyc, 32'(pc_redirect[d]), 32'(s.e.pc_redirect));
            chk("busy",        d, s.cyc, 32'(busy[d]),        32'(s.e.busy));
`ifdef HAZARD_PERF_EN
            chk("stall_cnt",   d, s.cyc, stall_cnt[d],        s.sc);
            chk("flush_cnt",   d, s.cyc, flush_cnt[d],        s.fc);
`endif
            $display("cyc %0d dut%0d rst=%0b instr=%h rd=%0d wr=%0b ld=%0b br=%0b out=%b",
                     s.cyc, d, rst, ex_instr, mw_rd, mw_reg_wr, mw_is_load, br_taken,
                     {fwd_a[d], fwd_b[d], stall_if[d], bubble_mw[d], flush_ex[d],
                      pc_redirect[d], busy[d]});
         end
      end
   end

   localparam logic [31:0] ADD  = 32'h00728333;  // add x6, x5, x7
   localparam logic [31:0] NOPI = 32'h00000013;

   initial begin : drv
      logic [6:0]  opc_tab [9];
      logic [31:0] ins;
      opc_tab = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17};
      for (int d = 0; d < NDUT; d++) begin
         stall_left[d] = 0; flush_left[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
      end
      rst = 1'b0; ex_instr = NOPI; mw_rd = 5'd0; mw_reg_wr = 1'b0;
      mw_is_load = 1'b0; br_taken = 1'b0;
      @(posedge clk);
      #1;

      // reset with hazard-looking inputs: outputs must stay low
      step(1'b0, ADD, 5'd5, 1'b1, 1'b1, 1'b1);
      step(1'b0, NOPI, 5'd0, 1'b0, 1'b0, 0);
      step(1'b1, NOPI, 5'd0, 1'b0, 1'b0, 0);
      // ALU forwarding on A, then on B
      step(1'b1, ADD, 5'd5, 1'b1, 1'b0, 0);
      step(1'b1, ADD, 5'd7, 1'b1, 1'b0, 0);
      // load-use followed by bubbles in MEM/WB
      step(1'b1, ADD, 5'd5, 1'b1, 1'b1, 0);
      repeat (3) step(1'b1, ADD, 5'd0, 1'b0, 1'b0, 0);
      // no false hazards: rd=x0, and lui whose rs1 field aliases x5
      step(1'b1, 32'h00000333, 5'd0, 1'b1, 1'b0, 0);
      step(1'b1, 32'h000282B7, 5'd5, 1'b1, 1'b1, 0);
      // branch held taken for three cycles
      repeat (3) step(1'b1, NOPI, 5'd0, 1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b1, NOPI, 5'd0, 1'b0, 1'b0, 1'b0);
      // load-use and branch together: stall wins, branch follows
      step(1'b1, ADD, 5'd5, 1'b1, 1'b1, 1'b1);
      repeat (3) step(1'b1, ADD, 5'd0, 1'b0, 1'b0, 1'b1);
      repeat (4) step(1'b1, NOPI, 5'd0, 1'b0, 1'b0, 1'b0);
      // reset in the second stall cycle, then a fresh load-use
      step(1'b1, ADD, 5'd5, 1'b1, 1'b1, 0);
      step(1'b1, ADD, 5'd0, 1'b0, 1'b0, 0);
      step(1'b0, ADD, 5'd0, 1'b0, 1'b0, 0);
      step(1'b1, NOPI, 5'd0, 1'b0, 1'b0, 0);
      step(1'b1, ADD, 5'd7, 1'b1, 1'b1, 0);
      repeat (4) step(1'b1, NOPI, 5'd0, 1'b0, 1'b0, 0);
      // same reset scenario during a flush
      step(1'b1, NOPI, 5'd0, 1'b0, 1'b0, 1'b1);
      step(1'b0, NOPI, 5'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, NOPI, 5'd0, 1'b0, 1'b0, 1'b0);

      // randomized traffic with small register numbers to provoke matches
      for (int i = 0; i < 600; i++) begin
         ins = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom), opc_tab[$urandom_range(0, 8)]};
         step(($urandom_range(0, 49) != 0), ins, 5'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      end

      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         n_vec++;
         if (sb_q[d].size() != 0) begin
            n_miss++;
            $display("FAIL drain dut%0d: got %0d pending expected 0", d, sb_q[d].size());
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin : watchdog
      #200000;
      n_miss++;
      $display("FAIL timeout: got no end of stimulus expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $fatal(1, "watchdog expired");
   end

endmodule
